adventure_move_sequencer: RTL and testbench

//  Front-end controller for the adventure-game room FSM. Synchronises raw N/S/E/W

---
 rtl/adventure_move_sequencer.sv | 151 +++++++++++++++
 tb/tb_adventure_move_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adventure_move_sequencer.sv
// Button front end for the adventure room FSM: sync, edge-detect, arbitrate,
// then issue one spaced move pulse per press until win, death or move limit.
module adventure_move_sequencer #(
    parameter int COOLDOWN = 4,
    parameter int MAX_MOVES = 15,
    localparam int CW = $clog2(MAX_MOVES + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          restart,
    input  logic          btn_n,
    input  logic          btn_s,
    input  logic          btn_e,
    input  logic          btn_w,
    input  logic          win_i,
    input  logic          dead_i,
    output logic          mv_n,
    output logic          mv_s,
    output logic          mv_e,
    output logic          mv_w,
    output logic [CW-1:0] move_count,
    output logic          busy,
    output logic          game_over,
    output logic          timeout
);

    localparam int DW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [DW-1:0] CD_LOAD = DW'(COOLDOWN - 1);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_MOVES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_COOL,
        S_DONE
    } state_t;

    state_t state, state_next;

    // Direction bit order everywhere: 0=N, 1=S, 2=E, 3=W
    logic [3:0] btn, s1, s2, s3, rise;
    logic [3:0] pending, pending_next;
    logic [3:0] grant, mv, mv_next;
    logic [DW-1:0] cd, cd_next;
    logic [CW-1:0] count_next;
    logic timeout_next;
    logic start, stop;

    assign btn  = {btn_w, btn_e, btn_s, btn_n};
    assign rise = s2 & ~s3;
    assign stop = win_i | dead_i;

    // Fixed priority N > E > W > S
    always_comb begin
        grant = 4'b0000;
        if (pending[0])      grant = 4'b0001;
        else if (pending[2]) grant = 4'b0100;
        else if (pending[3]) grant = 4'b1000;
        else if (pending[1]) grant = 4'b0010;
    end

    always_comb begin
        state_next   = state;
        pending_next = pending | rise;
        cd_next      = cd;
        count_next   = move_count;
        mv_next      = 4'b0000;
        timeout_next = timeout;
        start        = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (stop)          state_next = S_DONE;
                else if (|pending) start = 1'b1;
            end
            S_ISSUE: begin
                if (stop) begin
                    state_next = S_DONE;
                end else if (move_count == LIMIT) begin
                    state_next   = S_DONE;
                    timeout_next = 1'b1;
                end else begin
                    state_next = S_COOL;
                    cd_next    = CD_LOAD;
                end
            end
            S_COOL: begin
                if (stop) begin
                    state_next = S_DONE;
                end else if (cd == '0) begin
                    // Cooldown expiry falls straight into the idle decision
                    if (|pending) start = 1'b1;
                    else          state_next = S_IDLE;
                end else begin
                    cd_next = cd - DW'(1);
                end
            end
            S_DONE: begin
                state_next = S_DONE;
            end
        endcase
        if (start) begin
            state_next   = S_ISSUE;
            mv_next      = grant;
            pending_next = (pending & ~grant) | rise;
            if (move_count != LIMIT) count_next = move_count + CW'(1);
        end
        if (state_next == S_DONE) pending_next = 4'b0000;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            s1         <= '0;
            s2         <= '0;
            s3         <= '0;
            pending    <= '0;
            mv         <= '0;
            cd         <= '0;
            move_count <= '0;
            timeout    <= 1'b0;
        end else if (restart) begin
            state      <= S_IDLE;
            s1         <= '0;
            s2         <= '0;
            s3         <= '0;
            pending    <= '0;
            mv         <= '0;
            cd         <= '0;
            move_count <= '0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_next;
            s1         <= btn;
            s2         <= s1;
            s3         <= s2;
            pending    <= pending_next;
            mv         <= mv_next;
            cd         <= cd_next;
            move_count <= count_next;
            timeout    <= timeout_next;
        end
    end

    assign mv_n      = mv[0];
    assign mv_s      = mv[1];
    assign mv_e      = mv[2];
    assign mv_w      = mv[3];
    assign busy      = (state == S_ISSUE) || (state == S_COOL);
    assign game_over = (state == S_DONE);

endmodule

// File: tb/tb_adventure_move_sequencer.sv
// Directed and randomized bench for adventure_move_sequencer against a
// timing-level reference model of presses, spacing and game end.
module tb_adventure_move_sequencer;

    localparam int COOLDOWN = 4;
    localparam int MAX_MOVES = 15;
    localparam int CW = $clog2(MAX_MOVES + 1);

    logic clk = 1'b0;
    logic reset, restart;
    logic btn_n, btn_s, btn_e, btn_w;
    logic win_i, dead_i;
    logic mv_n, mv_s, mv_e, mv_w;
    logic [CW-1:0] move_count;
    logic busy, game_over, timeout;

    always #5 clk = ~clk;

    adventure_move_sequencer #(
        .COOLDOWN(COOLDOWN),
        .MAX_MOVES(MAX_MOVES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .restart(restart),
        .btn_n(btn_n),
        .btn_s(btn_s),
        .btn_e(btn_e),
        .btn_w(btn_w),
        .win_i(win_i),
        .dead_i(dead_i),
        .mv_n(mv_n),
        .mv_s(mv_s),
        .mv_e(mv_e),
        .mv_w(mv_w),
        .move_count(move_count),
        .busy(busy),
        .game_over(game_over),
        .timeout(timeout)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: button levels per edge, moves as timestamps
    logic [3:0] hist [0:4095];
    int e;
    int m_last;
    int m_moves;
    logic [3:0] m_pend;
    logic [3:0] m_mv;
    bit m_over;
    bit m_to;

    function automatic logic [3:0] mvv();
        return {mv_w, mv_e, mv_s, mv_n};
    endfunction

    function automatic logic [3:0] pick(input logic [3:0] p);
        if (p[0]) return 4'b0001;
        if (p[2]) return 4'b0100;
        if (p[3]) return 4'b1000;
        if (p[1]) return 4'b0010;
        return 4'b0000;
    endfunction

    function automatic void model_reset();
        e = 0;
        hist[0] = 4'b0000;
        m_last = -1000;
        m_moves = 0;
        m_pend = 4'b0000;
        m_mv = 4'b0000;
        m_over = 1'b0;
        m_to = 1'b0;
    endfunction

    function automatic void model_edge(input logic [3:0] b, input bit stop);
        logic [3:0] rise, g, h2, h3;
        e++;
        hist[e] = b;
        m_mv = 4'b0000;
        h2 = (e >= 2) ? hist[e-2] : 4'b0000;
        h3 = (e >= 3) ? hist[e-3] : 4'b0000;
        rise = h2 & ~h3;
        if (m_over) begin
            m_pend = 4'b0000;
            return;
        end
        if (stop) begin
            m_over = 1'b1;
            m_to = 1'b0;
            m_pend = 4'b0000;
            return;
        end
        if (e == m_last + 1 && m_moves == MAX_MOVES) begin
            m_over = 1'b1;
            m_to = 1'b1;
            m_pend = 4'b0000;
            return;
        end
        if (m_pend != 4'b0000 && e >= m_last + COOLDOWN + 1) begin
            g = pick(m_pend);
            m_mv = g;
            m_pend = m_pend & ~g;
            m_moves++;
            m_last = e;
        end
        m_pend = m_pend | rise;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s @edge %0d: observed %0h expected %0h",
                   tag, e, obs, exp);
        end
    endtask

    task automatic compare_all();
        bit mb;
        mb = !m_over && ((e - m_last) <= COOLDOWN);
        chk("mv", 32'(mvv()), 32'(m_mv));
        chk("count", 32'(move_count), 32'(m_moves));
        chk("busy", 32'(busy), 32'(mb));
        chk("game_over", 32'(game_over), 32'(m_over));
        chk("timeout", 32'(timeout), 32'(m_to));
    endtask

    task automatic step(input logic [3:0] b, input bit w, input bit d,
                        input bit rs);
        @(negedge clk);
        {btn_w, btn_e, btn_s, btn_n} = b;
        win_i = w;
        dead_i = d;
        restart = rs;
        @(posedge clk);
        if (rs) model_reset();
        else model_edge(b, w | d);
        #1;
        compare_all();
    endtask

    initial begin
        logic [3:0] cur;
        logic [3:0] b;
        reset = 1'b1;
        restart = 1'b0;
        {btn_w, btn_e, btn_s, btn_n} = 4'b0000;
        win_i = 1'b0;
        dead_i = 1'b0;
        model_reset();
        #12;
        compare_all();
        chk("rst_count", 32'(move_count), 32'd0);
        #5;
        reset = 1'b0;
        repeat (4) step(4'b0000, 0, 0, 0);

        // Single held press
        for (int i = 0; i < 20; i++) begin
            step(4'b0001, 0, 0, 0);
            if (i == 3) chk("t1_pulse", 32'(mvv()), 32'h1);
            else chk("t1_quiet", 32'(mvv()), 32'h0);
            if (i == 7) chk("t1_busy_hi", 32'(busy), 32'd1);
            if (i == 8) chk("t1_busy_lo", 32'(busy), 32'd0);
        end
        chk("t1_count", 32'(move_count), 32'd1);
        repeat (4) step(4'b0000, 0, 0, 0);

        // E and S together: E first, S five cycles later
        for (int i = 0; i < 15; i++) begin
            step(4'b0110, 0, 0, 0);
            if (i == 3) chk("t2_east", 32'(mvv()), 32'h4);
            if (i == 8) chk("t2_south", 32'(mvv()), 32'h2);
        end
        repeat (4) step(4'b0000, 0, 0, 0);
        chk("t2_count", 32'(move_count), 32'd3);

        // W pressed during cooldown is served right after it
        for (int i = 0; i < 14; i++) begin
            if (i < 2) b = 4'b0100;
            else if (i == 5 || i == 6) b = 4'b1000;
            else b = 4'b0000;
            step(b, 0, 0, 0);
            if (i == 3) chk("t3_east", 32'(mvv()), 32'h4);
            if (i == 8) chk("t3_west", 32'(mvv()), 32'h8);
        end
        chk("t3_count", 32'(move_count), 32'd5);

        // Ten more presses reach the move limit
        for (int p = 0; p < 10; p++)
            for (int i = 0; i < 8; i++)
                step((i < 2) ? 4'b0001 : 4'b0000, 0, 0, 0);
        chk("t4_over", 32'(game_over), 32'd1);
        chk("t4_timeout", 32'(timeout), 32'd1);
        chk("t4_count", 32'(move_count), 32'd15);
        for (int i = 0; i < 10; i++) begin
            step(4'b0100, 0, 0, 0);
            chk("t4_no_16th", 32'(mvv()), 32'h0);
        end

        // Death while presses pending
        step(4'b0000, 0, 0, 1);
        chk("t5_restart_count", 32'(move_count), 32'd0);
        chk("t5_restart_over", 32'(game_over), 32'd0);
        repeat (3) step(4'b0000, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step((i < 4) ? 4'b0011 : 4'b0000, 0, (i == 3), 0);
            chk("t5_no_pulse", 32'(mvv()), 32'h0);
        end
        chk("t5_over", 32'(game_over), 32'd1);
        chk("t5_timeout", 32'(timeout), 32'd0);
        step(4'b0000, 0, 0, 1);
        chk("t5_count", 32'(move_count), 32'd0);
        chk("t5_idle", 32'(game_over), 32'd0);

        // Async reset mid-ISSUE, button still held afterwards
        repeat (3) step(4'b0000, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(4'b0001, 0, 0, 0);
            if (i == 3) chk("t6_pre_pulse", 32'(mvv()), 32'h1);
        end
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_mv", 32'(mvv()), 32'h0);
        model_reset();
        compare_all();
        @(posedge clk);
        #2;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(4'b0001, 0, 0, 0);
            if (i == 3) chk("t6_post_pulse", 32'(mvv()), 32'h1);
            else chk("t6_post_quiet", 32'(mvv()), 32'h0);
        end

        // Randomized games, each started by restart
        for (int r = 0; r < 8; r++) begin
            cur = 4'($urandom_range(0, 15));
            step(cur, 0, 0, 1);
            for (int i = 0; i < 200; i++) begin
                for (int j = 0; j < 4; j++)
                    if ($urandom_range(0, 19) == 0) cur[j] = ~cur[j];
                step(cur, ($urandom_range(0, 249) == 0),
                     ($urandom_range(0, 249) == 0), 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
